// File: rtl/clint_arb.sv
// clint_arb: multi-source core-local interrupt arbiter. Picks between
// synchronous traps, level-sensitive external sources and MRET, then walks
// the mepc/mstatus/mcause CSR writes before a one-cycle redirect.
module clint_arb #(
    parameter int NUM_SRC        = 8,
    parameter int CPU_WIDTH      = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int CAUSE_BASE     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        int_src_i,
    input  logic [NUM_SRC-1:0]        int_en_i,
    input  logic [CPU_WIDTH-1:0]      wb_inst_i,
    input  logic [CPU_WIDTH-1:0]      wb_inst_addr_i,
    input  logic [CPU_WIDTH-1:0]      irq_epc_i,
    input  logic [CPU_WIDTH-1:0]      csr_mtvec,
    input  logic [CPU_WIDTH-1:0]      csr_mepc,
    input  logic [CPU_WIDTH-1:0]      csr_mstatus,
    output logic                      we_o,
    output logic [CSR_ADDR_WIDTH-1:0] waddr_o,
    output logic [CPU_WIDTH-1:0]      data_o,
    output logic                      hold_flag_o,
    output logic                      int_assert_o,
    output logic [CPU_WIDTH-1:0]      int_addr_o,
    output logic [NUM_SRC-1:0]        int_ack_o
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [CPU_WIDTH-1:0] INST_ECALL  = CPU_WIDTH'(32'h0000_0073);
    localparam logic [CPU_WIDTH-1:0] INST_EBREAK = CPU_WIDTH'(32'h0010_0073);
    localparam logic [CPU_WIDTH-1:0] INST_MRET   = CPU_WIDTH'(32'h3020_0073);

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);

    localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL  = CPU_WIDTH'(11);
    localparam logic [CPU_WIDTH-1:0] CAUSE_EBREAK = CPU_WIDTH'(3);
    localparam logic [CPU_WIDTH-1:0] CAUSE_BASE_W = CPU_WIDTH'(CAUSE_BASE);
    localparam logic [CPU_WIDTH-1:0] ASYNC_FLAG   = {1'b1, {(CPU_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MSTATUS,
        W_MCAUSE,
        ASSERT,
        R_MSTATUS,
        R_ASSERT
    } state_t;

    state_t               state_q, state_d;
    logic [CPU_WIDTH-1:0] epc_q, epc_d;
    logic [CPU_WIDTH-1:0] cause_q, cause_d;
    logic                 is_async_q, is_async_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [NUM_SRC-1:0]   pend;
    logic [IDX_W-1:0]     win_idx;
    logic                 sync_req;
    logic                 async_req;
    logic                 mret_req;
    logic [CPU_WIDTH-1:0] trap_base;
    logic [CPU_WIDTH-1:0] vec_off;

    // Classify the incoming request and find the lowest-indexed pending source; held off during reset
    always_comb begin
        pend    = int_src_i & int_en_i;
        win_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                win_idx = IDX_W'(i);
            end
        end
        sync_req  = !rst && ((wb_inst_i == INST_ECALL) || (wb_inst_i == INST_EBREAK));
        async_req = !rst && (|pend) && csr_mstatus[3];
        mret_req  = !rst && (wb_inst_i == INST_MRET);
    end

    // Next-state logic; trap context is captured only on the IDLE detection edge
    always_comb begin
        state_d    = state_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        is_async_d = is_async_q;
        idx_d      = idx_q;
        case (state_q)
            IDLE: begin
                if (sync_req) begin
                    state_d    = W_MEPC;
                    epc_d      = wb_inst_addr_i;
                    cause_d    = (wb_inst_i == INST_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK;
                    is_async_d = 1'b0;
                    idx_d      = '0;
                end else if (async_req) begin
                    state_d    = W_MEPC;
                    epc_d      = irq_epc_i;
                    cause_d    = ASYNC_FLAG | (CAUSE_BASE_W + CPU_WIDTH'(win_idx));
                    is_async_d = 1'b1;
                    idx_d      = win_idx;
                end else if (mret_req) begin
                    state_d = R_MSTATUS;
                end
            end
            W_MEPC:    state_d = W_MSTATUS;
            W_MSTATUS: state_d = W_MCAUSE;
            W_MCAUSE:  state_d = ASSERT;
            ASSERT:    state_d = IDLE;
            R_MSTATUS: state_d = R_ASSERT;
            R_ASSERT:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode of the registered state; mtvec/mstatus/mepc are used live in their cycle
    always_comb begin
        we_o         = 1'b0;
        waddr_o      = '0;
        data_o       = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        int_ack_o    = '0;
        hold_flag_o  = (state_q != IDLE) || sync_req || async_req || mret_req;
        trap_base    = {csr_mtvec[CPU_WIDTH-1:2], 2'b00};
        vec_off      = (CAUSE_BASE_W + CPU_WIDTH'(idx_q)) << 2;
        case (state_q)
            W_MEPC: begin
                we_o    = 1'b1;
                waddr_o = ADDR_MEPC;
                data_o  = epc_q;
            end
            W_MSTATUS: begin
                we_o      = 1'b1;
                waddr_o   = ADDR_MSTATUS;
                data_o    = csr_mstatus;
                data_o[7] = csr_mstatus[3];
                data_o[3] = 1'b0;
            end
            W_MCAUSE: begin
                we_o    = 1'b1;
                waddr_o = ADDR_MCAUSE;
                data_o  = cause_q;
            end
            ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = ((csr_mtvec[1:0] == 2'b01) && is_async_q) ? (trap_base + vec_off)
                                                                         : trap_base;
                if (is_async_q) begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        int_ack_o[i] = (idx_q == IDX_W'(i));
                    end
                end
            end
            R_MSTATUS: begin
                we_o      = 1'b1;
                waddr_o   = ADDR_MSTATUS;
                data_o    = csr_mstatus;
                data_o[3] = csr_mstatus[7];
                data_o[7] = 1'b1;
            end
            R_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc;
            end
            default: ;
        endcase
    end

    // State and latched trap context; reset aborts any sequence in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            epc_q      <= '0;
            cause_q    <= '0;
            is_async_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            is_async_q <= is_async_d;
            idx_q      <= idx_d;
        end
    end

endmodule

// File: tb/tb_clint_arb.sv
// tb_clint_arb: vector table, hand-built corner sequences and randomized
// requests checked against a behavioural model of clint_arb.
module tb_clint_arb;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  int_src_i, int_en_i;
    logic [31:0] wb_inst_i, wb_inst_addr_i, irq_epc_i;
    logic [31:0] csr_mtvec, csr_mepc, csr_mstatus;
    logic        we_o, hold_flag_o, int_assert_o;
    logic [11:0] waddr_o;
    logic [31:0] data_o, int_addr_o;
    logic [7:0]  int_ack_o;

    int assertCount = 0;
    int failCount   = 0;

    // kind: 0 = no activity, 1 = trap, 2 = MRET
    typedef struct {
        logic [31:0] inst, addr, irq_epc, mtvec, mepc, mstatus;
        logic [7:0]  src, en;
        bit          hold_src;
        int          kind;
        logic [31:0] exp_epc, exp_mst, exp_cause, exp_target;
        logic [7:0]  exp_ack;
    } vec_t;

    vec_t table_v[$];

    clint_arb #(
        .NUM_SRC(8), .CPU_WIDTH(32), .CSR_ADDR_WIDTH(12), .CAUSE_BASE(16)
    ) dut (
        .clk(clk), .rst(rst),
        .int_src_i(int_src_i), .int_en_i(int_en_i),
        .wb_inst_i(wb_inst_i), .wb_inst_addr_i(wb_inst_addr_i),
        .irq_epc_i(irq_epc_i), .csr_mtvec(csr_mtvec),
        .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
        .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
        .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o), .int_ack_o(int_ack_o)
    );

    // Free-running 10 ns core clock
    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input logic [31:0] inst, addr, irq_epc, mtvec, mepc, mstatus,
        input logic [7:0] src, en, input bit hold_src, input int kind,
        input logic [31:0] exp_epc, exp_mst, exp_cause, exp_target,
        input logic [7:0] exp_ack);
        vec_t v;
        v.inst = inst; v.addr = addr; v.irq_epc = irq_epc; v.mtvec = mtvec;
        v.mepc = mepc; v.mstatus = mstatus; v.src = src; v.en = en;
        v.hold_src = hold_src; v.kind = kind; v.exp_epc = exp_epc;
        v.exp_mst = exp_mst; v.exp_cause = exp_cause; v.exp_target = exp_target;
        v.exp_ack = exp_ack;
        return v;
    endfunction

    // Reference model: straight from the arbitration and CSR-update rules
    function automatic vec_t predict(input vec_t v);
        vec_t        r    = v;
        logic [7:0]  p    = v.src & v.en;
        logic [31:0] base = v.mtvec & ~32'h3;
        int          idx  = 0;
        r.kind = 0; r.exp_epc = 0; r.exp_mst = 0; r.exp_cause = 0;
        r.exp_target = 0; r.exp_ack = 0;
        if (v.inst == ECALL || v.inst == EBREAK) begin
            r.kind       = 1;
            r.exp_epc    = v.addr;
            r.exp_cause  = (v.inst == ECALL) ? 32'd11 : 32'd3;
            r.exp_mst    = (v.mstatus & ~32'h88) | (v.mstatus[3] ? 32'h80 : 32'h0);
            r.exp_target = base;
        end else if (p != 0 && v.mstatus[3]) begin
            while (!p[idx]) idx++;
            r.kind       = 1;
            r.exp_epc    = v.irq_epc;
            r.exp_cause  = 32'h8000_0000 + 32'(16 + idx);
            r.exp_mst    = (v.mstatus & ~32'h88) | 32'h80;
            r.exp_target = base + ((v.mtvec[1:0] == 2'b01) ? 32'(4 * (16 + idx)) : 32'h0);
            r.exp_ack    = 8'(1 << idx);
        end else if (v.inst == MRET) begin
            r.kind       = 2;
            r.exp_mst    = (v.mstatus & ~32'h8) | 32'h80 | (v.mstatus[7] ? 32'h8 : 32'h0);
            r.exp_target = v.mepc;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, " hold"},   32'(hold_flag_o),  32'h0);
        checkOutput({tag, " we"},     32'(we_o),         32'h0);
        checkOutput({tag, " assert"}, 32'(int_assert_o), 32'h0);
        checkOutput({tag, " ack"},    32'(int_ack_o),    32'h0);
    endtask

    task automatic applyStimulus(input vec_t v);
        wb_inst_i      = v.inst;
        wb_inst_addr_i = v.addr;
        irq_epc_i      = v.irq_epc;
        csr_mtvec      = v.mtvec;
        csr_mepc       = v.mepc;
        csr_mstatus    = v.mstatus;
        int_src_i      = v.src;
        int_en_i       = v.en;
    endtask

    // After detection the bench scrambles latched-at-detection inputs to prove they were captured
    task automatic scramble(input vec_t v);
        wb_inst_i      = NOP;
        wb_inst_addr_i = $urandom;
        irq_epc_i      = $urandom;
        if (!v.hold_src) int_src_i = 8'h00;
    endtask

    task automatic runVector(input vec_t v, input string tag);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput({tag, " det hold"},   32'(hold_flag_o),  32'(v.kind != 0));
        checkOutput({tag, " det we"},     32'(we_o),         32'h0);
        checkOutput({tag, " det assert"}, 32'(int_assert_o), 32'h0);
        if (v.kind == 0) begin
            repeat (2) begin
                @(negedge clk); #1;
                checkQuiet({tag, " masked"});
            end
        end else if (v.kind == 1) begin
            @(negedge clk); scramble(v); #1;
            checkOutput({tag, " mepc we"},    32'(we_o),        32'h1);
            checkOutput({tag, " mepc addr"},  32'(waddr_o),     32'h341);
            checkOutput({tag, " mepc data"},  data_o,           v.exp_epc);
            checkOutput({tag, " mepc hold"},  32'(hold_flag_o), 32'h1);
            @(negedge clk); #1;
            checkOutput({tag, " mst we"},     32'(we_o),        32'h1);
            checkOutput({tag, " mst addr"},   32'(waddr_o),     32'h300);
            checkOutput({tag, " mst data"},   data_o,           v.exp_mst);
            @(negedge clk); #1;
            checkOutput({tag, " cause we"},   32'(we_o),        32'h1);
            checkOutput({tag, " cause addr"}, 32'(waddr_o),     32'h342);
            checkOutput({tag, " cause data"}, data_o,           v.exp_cause);
            @(negedge clk);
            csr_mstatus = v.exp_mst;
            #1;
            checkOutput({tag, " asrt we"},    32'(we_o),         32'h0);
            checkOutput({tag, " asrt strobe"},32'(int_assert_o), 32'h1);
            checkOutput({tag, " asrt target"},int_addr_o,        v.exp_target);
            checkOutput({tag, " asrt ack"},   32'(int_ack_o),    32'(v.exp_ack));
            checkOutput({tag, " asrt hold"},  32'(hold_flag_o),  32'h1);
        end else begin
            @(negedge clk); scramble(v); #1;
            checkOutput({tag, " mret we"},    32'(we_o),        32'h1);
            checkOutput({tag, " mret addr"},  32'(waddr_o),     32'h300);
            checkOutput({tag, " mret data"},  data_o,           v.exp_mst);
            @(negedge clk);
            csr_mstatus = v.exp_mst;
            #1;
            checkOutput({tag, " mret strobe"},32'(int_assert_o), 32'h1);
            checkOutput({tag, " mret target"},int_addr_o,        v.exp_target);
            checkOutput({tag, " mret we0"},   32'(we_o),         32'h0);
            checkOutput({tag, " mret ack"},   32'(int_ack_o),    32'h0);
        end
    endtask

    task automatic idleCheck(input string tag);
        @(negedge clk);
        wb_inst_i = NOP;
        int_src_i = 8'h00;
        #1;
        checkQuiet({tag, " idle"});
    endtask

    // Main test: reset, vector table, corner sequences, mid-sequence reset, random
    initial begin
        vec_t v;
        rst = 1'b1;
        int_src_i = 0; int_en_i = 0; wb_inst_i = NOP; wb_inst_addr_i = 0;
        irq_epc_i = 0; csr_mtvec = 0; csr_mepc = 0; csr_mstatus = 0;
        repeat (2) @(negedge clk);
        #1;
        checkQuiet("reset");
        checkOutput("reset data",  data_o,          32'h0);
        checkOutput("reset waddr", 32'(waddr_o),    32'h0);
        checkOutput("reset iaddr", int_addr_o,      32'h0);
        @(negedge clk);
        rst = 1'b0;

        //                 inst    addr        irq_epc     mtvec        mepc      mst          src    en     hs kind epc         mst          cause          target       ack
        table_v.push_back(mkVec(ECALL,  32'h100, 32'h0,   32'h200,  32'h0,   32'h8,    8'h00, 8'h00, 0, 1, 32'h100, 32'h80,   32'd11,        32'h200,  8'h00));
        table_v.push_back(mkVec(EBREAK, 32'h3c,  32'h0,   32'h301,  32'h0,   32'h1888, 8'h00, 8'h00, 0, 1, 32'h3c,  32'h1880, 32'd3,         32'h300,  8'h00));
        table_v.push_back(mkVec(NOP,    32'h999, 32'h40,  32'h201,  32'h0,   32'h8,    8'h24, 8'hFF, 0, 1, 32'h40,  32'h80,   32'h8000_0012, 32'h248,  8'h04));
        table_v.push_back(mkVec(NOP,    32'h0,   32'h40,  32'h201,  32'h0,   32'h8,    8'h24, 8'h00, 0, 0, 32'h0,   32'h0,    32'h0,         32'h0,    8'h00));
        table_v.push_back(mkVec(NOP,    32'h0,   32'h40,  32'h201,  32'h0,   32'h0,    8'h24, 8'hFF, 0, 0, 32'h0,   32'h0,    32'h0,         32'h0,    8'h00));
        table_v.push_back(mkVec(MRET,   32'h0,   32'h0,   32'h200,  32'h104, 32'h80,   8'h00, 8'h00, 0, 2, 32'h0,   32'h88,   32'h0,         32'h104,  8'h00));
        table_v.push_back(mkVec(NOP,    32'h0,   32'h500, 32'h1001, 32'h0,   32'h88,   8'h80, 8'hFF, 0, 1, 32'h500, 32'h80,   32'h8000_0017, 32'h105C, 8'h80));
        table_v.push_back(mkVec(NOP,    32'h0,   32'h77,  32'h400,  32'h0,   32'h8,    8'h81, 8'h80, 0, 1, 32'h77,  32'h80,   32'h8000_0017, 32'h400,  8'h80));
        table_v.push_back(mkVec(ECALL,  32'h200, 32'h0,   32'h201,  32'h0,   32'h8,    8'h01, 8'hFF, 0, 1, 32'h200, 32'h80,   32'd11,        32'h200,  8'h00));
        table_v.push_back(mkVec(MRET,   32'h0,   32'h88,  32'h200,  32'h104, 32'h8,    8'h10, 8'hFF, 0, 1, 32'h88,  32'h80,   32'h8000_0014, 32'h200,  8'h10));

        foreach (table_v[i]) begin
            runVector(table_v[i], $sformatf("vec%0d", i));
            idleCheck($sformatf("vec%0d", i));
        end

        // ECALL with src0 pending: sync first, src0 masked while MIE=0, MRET, then src0
        runVector(mkVec(ECALL, 32'h100, 32'h0, 32'h201, 32'h0, 32'h8, 8'h01, 8'h01, 1, 1,
                        32'h100, 32'h80, 32'd11, 32'h200, 8'h00), "coinc ecall");
        repeat (3) begin
            @(negedge clk); #1;
            checkQuiet("coinc masked");
        end
        runVector(mkVec(MRET, 32'h0, 32'h0, 32'h201, 32'h104, 32'h80, 8'h01, 8'h01, 1, 2,
                        32'h0, 32'h88, 32'h0, 32'h104, 8'h00), "coinc mret");
        runVector(mkVec(NOP, 32'h0, 32'h104, 32'h201, 32'h0, 32'h88, 8'h01, 8'h01, 0, 1,
                        32'h104, 32'h80, 32'h8000_0010, 32'h240, 8'h01), "coinc src0");
        idleCheck("coinc");

        // Reset asserted while the mstatus write is on the bus
        @(negedge clk); applyStimulus(table_v[0]);
        @(negedge clk); scramble(table_v[0]);
        @(negedge clk); #1;
        checkOutput("rstseq mst we",   32'(we_o),    32'h1);
        checkOutput("rstseq mst addr", 32'(waddr_o), 32'h300);
        rst = 1'b1;
        #1;
        checkQuiet("rstseq during");
        checkOutput("rstseq data",  data_o,       32'h0);
        checkOutput("rstseq waddr", 32'(waddr_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            checkQuiet("rstseq after");
        end
        runVector(table_v[0], "rstseq rerun");
        idleCheck("rstseq rerun");

        // Randomized requests against the reference model
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 4))
                0: v.inst = ECALL;
                1: v.inst = EBREAK;
                2: v.inst = MRET;
                3: v.inst = NOP;
                default: v.inst = $urandom;
            endcase
            v.addr     = $urandom;
            v.irq_epc  = $urandom;
            v.mtvec    = $urandom;
            v.mepc     = $urandom;
            v.mstatus  = $urandom;
            v.src      = 8'($urandom_range(0, 255));
            v.en       = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            v.hold_src = 1'b0;
            v = predict(v);
            runVector(v, $sformatf("rand%0d", n));
            idleCheck($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/clint_arb.md
Name: clint_arb

Overview:
- Parametrised multi-source successor to the core-local interrupt controller.
- Arbitrates synchronous traps (ECALL/EBREAK), NUM_SRC level-sensitive external interrupt sources with per-source enable, and MRET.
- Sequences the mepc/mstatus/mcause CSR writes, then issues a single-cycle redirect to flow_ctrl.
- Adds fixed-priority source selection, RISC-V vectored mtvec mode, correct MPIE save/restore and a per-source claim acknowledge.

Parameters:
- NUM_SRC, 8, number of external interrupt sources (legal 1..32).
- CPU_WIDTH, 32, data/address width.
- CSR_ADDR_WIDTH, 12, CSR address width.
- CAUSE_BASE, 16, mcause exception code of source 0; source i uses CAUSE_BASE+i.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- int_src_i  in  NUM_SRC  level interrupt requests
- int_en_i  in  NUM_SRC  per-source enable mask
- wb_inst_i  in  CPU_WIDTH  instruction in write-back
- wb_inst_addr_i  in  CPU_WIDTH  write-back instruction address
- irq_epc_i  in  CPU_WIDTH  resume address for an async interrupt, from flow_ctrl
- csr_mtvec  in  CPU_WIDTH  mtvec value
- csr_mepc  in  CPU_WIDTH  mepc value
- csr_mstatus  in  CPU_WIDTH  mstatus value
- we_o  out  1  CSR write enable
- waddr_o  out  CSR_ADDR_WIDTH  CSR write address
- data_o  out  CPU_WIDTH  CSR write data
- hold_flag_o  out  1  pipeline hold
- int_assert_o  out  1  redirect strobe
- int_addr_o  out  CPU_WIDTH  redirect target
- int_ack_o  out  NUM_SRC  one-hot claim pulse

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; latched cause/epc/index cleared. Reset mid-sequence aborts the sequence, with no partial write beyond the cycle already emitted.
- Encodings: ECALL 32'h00000073, EBREAK 32'h00100073, MRET 32'h30200073.
- CSR addresses: mstatus 12'h300, mepc 12'h341, mcause 12'h342.
- Request detection, in IDLE only:
  - Priority: sync (ECALL/EBREAK on wb_inst_i) > async (any int_src_i & int_en_i bit set AND csr_mstatus[3]=1) > MRET.
  - Async winner is the lowest-indexed pending enabled source.
- On detection at edge T, latch:
  - epc: wb_inst_addr_i for sync, irq_epc_i for async.
  - mcause: sync = 11 (ECALL) or 3 (EBREAK) with bit31=0; async = {1'b1, CAUSE_BASE+idx}.
  - is_async flag and winner index.
- Trap sequence; outputs are a decode of the registered state, one state per cycle:
  - W_MEPC: we_o=1, waddr_o=mepc, data_o=epc.
  - W_MSTATUS: we_o=1, waddr_o=mstatus, data_o = csr_mstatus with bit7 (MPIE) set to csr_mstatus[3] and bit3 (MIE) cleared.
  - W_MCAUSE: we_o=1, waddr_o=mcause, data_o=cause.
  - ASSERT: we_o=0, int_assert_o=1, int_addr_o = target (below); if async, int_ack_o[idx]=1.
  - Then IDLE.
- Trap target: if csr_mtvec[1:0]==2'b01 and async, target = {csr_mtvec[CPU_WIDTH-1:2],2'b00} + 4*(CAUSE_BASE+idx). Otherwise target = {csr_mtvec[CPU_WIDTH-1:2],2'b00}. mtvec is sampled in the ASSERT cycle.
- MRET sequence:
  - R_MSTATUS: we_o=1, waddr_o=mstatus, data_o = csr_mstatus with bit3 set to csr_mstatus[7] and bit7 set to 1.
  - R_ASSERT: int_assert_o=1, int_addr_o=csr_mepc.
  - Then IDLE.
- Latency: trap redirect is asserted 4 cycles after the detection edge; MRET redirect 2 cycles after.
- hold_flag_o: combinational, 1 when state != IDLE, or when in IDLE and any request is detected that cycle. It is therefore high in the detection cycle and every non-IDLE cycle.
- Requests arriving while not in IDLE are ignored; level sources stay pending and are re-evaluated in the first IDLE cycle.
- A source dropping mid-sequence does not cancel the sequence; the claim and ack still complete.
- Async is masked when csr_mstatus[3]=0 or the source enable bit is 0.
- When ECALL and an async source coincide, the sync trap is taken first; the async is taken after return, once MIE is re-enabled.
- All unused output bits are 0 whenever not driven by a state.

Test Plan:
- Reset, then ECALL at wb_inst_addr_i=32'h100, mtvec=32'h200, mstatus=32'h8 -> CSR writes on three consecutive cycles: mepc=32'h100, mstatus=32'h80, mcause=32'd11; int_assert_o=1 with int_addr_o=32'h200 on the next cycle; hold_flag_o high for 5 cycles.
- int_src_i=8'b0010_0100, int_en_i=8'hFF, MIE=1, irq_epc_i=32'h40, mtvec=32'h201 -> source 2 wins; mcause=32'h80000012; int_addr_o=32'h248; int_ack_o=8'h04 for one cycle.
- Same source pattern with int_en_i=8'h00, or with mstatus=0 -> no activity; hold_flag_o stays 0.
- MRET with mstatus=32'h80, mepc=32'h104 -> single mstatus write of 32'h88; next cycle int_assert_o=1 with int_addr_o=32'h104.
- ECALL and src0 asserted in the same cycle -> sync trap (mcause 11) only; src0 is not taken while MIE=0.
- Assert rst during W_MSTATUS -> all outputs 0 immediately; state IDLE; a new request after reset runs the full sequence.
